serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

- Serial pattern transmitter: the driving end of the bit-serial line that our sequence detectors sample.
- On a one-cycle start request it latches a WIDTH-bit pattern and a repeat count.
- It then shifts the pattern out MSB-first on X, repeat_n times, with GAP idle-zero bits between repetitions, and pulses done when finished.
- Used as the stimulus source for detector labs and as the transmit half of the serial link.

## Interface
- WIDTH, 4, pattern length in bits (≥2)
- GAP, 1, idle '0' bits inserted between repetitions (0 = back-to-back)
- CNT_W, 4, width of repeat count
- Clocking: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces IDLE
- start  input  1  frame request, sampled only in IDLE
- pattern  input  WIDTH  bits to send, MSB first; latched on accepted start
- repeat_n  input  CNT_W  number of pattern repetitions; latched on accepted start
- X  output  1  serial line; 0 when not sending a pattern bit
- busy  output  1  high in SHIFT and GAP
- done  output  1  one-cycle pulse in DONE
- state  output  2  current FSM state, for debug/visibility

## Operation
- States:
  - IDLE = 2'b00
  - SHIFT = 2'b01
  - GAP = 2'b10
  - DONE = 2'b11
- Registers:
  - shreg[WIDTH-1:0]: shift register
  - pat_q: latched pattern
  - rep_cnt[CNT_W-1:0]
  - bit_cnt: ⌈log2 WIDTH⌉ bits
  - gap_cnt: ⌈log2(GAP+1)⌉ bits, min 1
- Outputs are Moore:
  - X = shreg[WIDTH-1] when state==SHIFT, else 0.
  - busy = (state==SHIFT || state==GAP).
  - done = (state==DONE).
- IDLE, start=1:
  - Load shreg and pat_q from pattern, and rep_cnt from repeat_n.
  - If repeat_n==0, go to DONE (no bits sent).
  - Otherwise set bit_cnt=WIDTH-1 and go to SHIFT.
- SHIFT, each cycle:
  - Shift shreg left by one, filling with 0.
  - If bit_cnt≠0: decrement bit_cnt.
  - If bit_cnt==0 (last bit of a repetition):
    - If rep_cnt==1: go to DONE.
    - Else decrement rep_cnt.
    - If GAP==0: reload shreg from pat_q, set bit_cnt=WIDTH-1, stay in SHIFT.
    - If GAP>0: set gap_cnt=GAP-1 and go to GAP.
- GAP:
  - X=0.
  - If gap_cnt≠0, decrement it.
  - Otherwise reload shreg from pat_q, set bit_cnt=WIDTH-1, and go to SHIFT.
- DONE: go to IDLE unconditionally.
- Boundary rules:
  - start outside IDLE (including DONE) is ignored, not queued.
  - pattern and repeat_n changes after acceptance have no effect on the frame in flight.
  - start held high continuously gives back-to-back frames separated by DONE plus one IDLE cycle.
  - repeat_n at its maximum value (2^CNT_W−1) is legal; the counter never wraps.
  - Asserting reset at any point, including mid-frame, immediately gives:
    - state=IDLE
    - X=0, busy=0, done=0
    - all counters and shreg cleared
    - the partial frame is abandoned
  - After reset deasserts, the first start is accepted normally.

## Timing
- Reset values: state=IDLE, X=0, busy=0, done=0.
- Start accepted at edge k: first pattern bit valid on X from edge k until edge k+1.
- Each bit is held exactly one clock cycle.
- busy is high for repeat_n·WIDTH + (repeat_n−1)·GAP cycles.
- done is high for the single cycle that follows busy.
- Earliest next start is sampled at the edge after done.
- repeat_n=0: done is high in the cycle after acceptance; busy never rises.
- All state changes occur on the rising edge of clk, except reset, which acts asynchronously.

## Structure
- Shared Verilog header serial_tx_defs.vh holds:
  - the state encodings IDLE/SHIFT/GAP/DONE
  - the default WIDTH, GAP and CNT_W
- The detector bench includes the same header.
- One sub-module, piso_shift, is the parallel-in/serial-out register:
  - parameter WIDTH
  - inputs clk, reset, load, shift, d[WIDTH-1:0]
  - output q_msb
- The top level holds the FSM and the three counters.

## Test plan
- Reset mid-frame: assert reset during the 3rd bit of a frame → X, busy and done go 0 immediately and state=00. A following start with 4'b1010, repeat_n=1 → X=1,0,1,0 then done.
- Default parameters, pattern=4'b1100, repeat_n=2, start for 1 cycle → X=1,1,0,0,0,1,1,0,0; busy high for 9 cycles; done high in cycle 10; the detector sees 1100 twice.
- GAP=0, pattern=4'b1000, repeat_n=3 → X=1,0,0,0,1,0,0,0,1,0,0,0; busy for 12 cycles; done once.
- repeat_n=0 with start → X stays 0, busy stays 0, done pulses in the next cycle.
- start held high for the whole test with repeat_n=1, pattern=4'b1100 → frames are separated by exactly 2 cycles (DONE, IDLE). Changing pattern mid-frame does not alter the current frame.
- repeat_n=4'b1111, WIDTH=4, GAP=1 → busy for 74 cycles, exactly 15 repetitions, no counter wrap.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding,
// default geometry and a counter-width helper.
package serial_pattern_tx_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_GAP   = 1;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } tx_state_e;

  // Bits needed to count down from max_val to 0, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Frame request / serial line bundle between a frame source and the transmitter.
interface serial_pattern_tx_if
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             X;
  logic             busy;
  logic             done;
  tx_state_e        state;

  modport master (output start, pattern, repeat_n, input X, busy, done, state);
  modport slave  (input start, pattern, repeat_n, output X, busy, done, state);
endinterface

// File: rtl/serial_pattern_tx_piso_shift.sv
// Parallel-in / serial-out register; load takes priority over shift, zeros fill from the LSB.
module piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);
  logic [WIDTH-1:0] shreg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      shreg <= '0;
    else if (load)  shreg <= d;
    else if (shift) shreg <= {shreg[WIDTH-2:0], 1'b0};
  end

  assign q_msb = shreg[WIDTH-1];
endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first repeat_n times,
// with GAP idle-zero bits between repetitions, then pulses done.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  serial_pattern_tx_if.slave  bus
);
  localparam int BIT_W = cnt_width(WIDTH - 1);
  localparam int GAP_W = cnt_width(GAP);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             load, shift, q_msb;

  // NOTE: every register, counters included, is cleared by the async reset so
  // a frame abandoned mid-flight leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

  // NOTE: all outputs of this block take a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load  = 1'b1;
          pat_d = bus.pattern;
          rep_d = bus.repeat_n;
          if (bus.repeat_n == '0) begin
            state_d = S_DONE;
          end else begin
            bit_d   = LAST_BIT;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (bit_q != '0) begin
          bit_d = bit_q - 1'b1;
        end else if (rep_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          rep_d = rep_q - 1'b1;
          if (GAP == 0) begin
            load  = 1'b1;
            bit_d = LAST_BIT;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          load    = 1'b1;
          bit_d   = LAST_BIT;
          state_d = S_SHIFT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // In IDLE the register loads straight from the request; later reloads use the latched copy.
  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     ((state_q == S_IDLE) ? bus.pattern : pat_q),
    .q_msb (q_msb)
  );

  assign bus.X     = (state_q == S_SHIFT) ? q_msb : 1'b0;
  assign bus.busy  = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign bus.done  = (state_q == S_DONE);
  assign bus.state = state_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: a frame table plus hand sequences for
// mid-frame reset, held start, GAP=0 and maximum repeat count.
module tb_serial_pattern_tx;
  import serial_pattern_tx_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(4), .CNT_W(4)) bus  ();
  serial_pattern_tx_if #(.WIDTH(4), .CNT_W(4)) bus0 ();

  serial_pattern_tx #(.WIDTH(4), .GAP(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  serial_pattern_tx #(.WIDTH(4), .GAP(0), .CNT_W(4)) dut_g0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  typedef struct {
    logic [3:0]  pattern;
    logic [3:0]  rep;
    int          len;     // busy cycles
    logic [31:0] exp_x;   // expected X stream, first bit at index len-1
  } frame_t;

  frame_t tv[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the default DUT idle; returns at a negedge in IDLE.
  task automatic run_frame(input int idx);
    frame_t f;
    f = tv[idx];
    bus.pattern  = f.pattern;
    bus.repeat_n = f.rep;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.pattern  = ~f.pattern;   // must not disturb the frame in flight
    bus.repeat_n = 4'd0;
    for (int i = 0; i < f.len; i++) begin
      check($sformatf("f%0d_x%0d", idx, i), 32'(bus.X), 32'(f.exp_x[f.len-1-i]));
      check($sformatf("f%0d_busy%0d", idx, i), 32'(bus.busy), 32'd1);
      check($sformatf("f%0d_done%0d", idx, i), 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    check($sformatf("f%0d_done", idx), 32'(bus.done), 32'd1);
    check($sformatf("f%0d_done_busy", idx), 32'(bus.busy), 32'd0);
    check($sformatf("f%0d_done_x", idx), 32'(bus.X), 32'd0);
    check($sformatf("f%0d_done_state", idx), 32'(bus.state), 32'd3);
    @(negedge clk);
    check($sformatf("f%0d_idle_done", idx), 32'(bus.done), 32'd0);
    check($sformatf("f%0d_idle_state", idx), 32'(bus.state), 32'd0);
  endtask

  logic [17:0] held_x;
  logic [17:0] held_done;
  logic [11:0] g0_x;

  initial begin
    tv[0] = '{pattern: 4'b1010, rep: 4'd1, len: 4,  exp_x: 32'b1010};
    tv[1] = '{pattern: 4'b1100, rep: 4'd2, len: 9,  exp_x: 32'b110001100};
    tv[2] = '{pattern: 4'b1111, rep: 4'd0, len: 0,  exp_x: 32'b0};
    tv[3] = '{pattern: 4'b1001, rep: 4'd3, len: 14, exp_x: 32'b10010100101001};
    tv[4] = '{pattern: 4'b0111, rep: 4'd1, len: 4,  exp_x: 32'b0111};
    held_x    = 18'b1100_00_0011_00_0011_00;
    held_done = 18'b0000_10_0000_10_0000_10;
    g0_x      = 12'b1000_1000_1000;

    reset = 1'b1;
    bus.start = 1'b0;  bus.pattern = '0;  bus.repeat_n = '0;
    bus0.start = 1'b0; bus0.pattern = '0; bus0.repeat_n = '0;
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_x", 32'(bus.X), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset during the third bit of a frame.
    bus.pattern = 4'b1111; bus.repeat_n = 4'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_bit3_x", 32'(bus.X), 32'd1);
    check("mid_bit3_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_x", 32'(bus.X), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_state", 32'(bus.state), 32'd0);

    for (int i = 0; i < 5; i++) run_frame(i);

    // start held high: frames separated by DONE + IDLE; pattern changed mid-frame.
    bus.pattern = 4'b1100; bus.repeat_n = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 18; c++) begin
      check($sformatf("held_x%0d", c), 32'(bus.X), 32'(held_x[17-c]));
      check($sformatf("held_done%0d", c), 32'(bus.done), 32'(held_done[17-c]));
      if (c == 1) bus.pattern = 4'b0011;
      if (c == 17) bus.start = 1'b0;
      @(negedge clk);
    end
    check("held_stop_state", 32'(bus.state), 32'd0);
    check("held_stop_busy", 32'(bus.busy), 32'd0);

    // GAP=0 instance: back-to-back repetitions.
    bus0.pattern = 4'b1000; bus0.repeat_n = 4'd3; bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("g0_x%0d", i), 32'(bus0.X), 32'(g0_x[11-i]));
      check($sformatf("g0_busy%0d", i), 32'(bus0.busy), 32'd1);
      @(negedge clk);
    end
    check("g0_done", 32'(bus0.done), 32'd1);
    check("g0_done_busy", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    check("g0_done_once", 32'(bus0.done), 32'd0);

    // Maximum repeat count: 15 repetitions of 1011 with one gap bit between.
    bus.pattern = 4'b1011; bus.repeat_n = 4'hF; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 74; i++) begin
      logic [3:0] p;
      logic       e;
      p = 4'b1011;
      e = ((i % 5) == 4) ? 1'b0 : p[3 - (i % 5)];
      check($sformatf("max_x%0d", i), 32'(bus.X), 32'(e));
      check($sformatf("max_busy%0d", i), 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    check("max_done", 32'(bus.done), 32'd1);
    check("max_done_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("max_idle_state", 32'(bus.state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
